// File: rtl/writeback_queue.sv
// Writeback queue: a circular FIFO of pending register-file writes, issued in order,
// with combinational forwarding of the youngest pending value for two lookup ports.
module writeback_queue #(
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     ctrl_reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [4:0]               in_reg,
    input  logic [31:0]              in_data,
    input  logic                     drain_hold,
    output logic                     ctrl_writeEnable,
    output logic [4:0]               ctrl_writeReg,
    output logic [31:0]              data_writeReg,
    input  logic [4:0]               lookup_regA,
    input  logic [4:0]               lookup_regB,
    output logic                     fwd_hitA,
    output logic                     fwd_hitB,
    output logic [31:0]              fwd_dataA,
    output logic [31:0]              fwd_dataB,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [4:0]       reg_mem_q  [DEPTH];
    logic [4:0]       reg_mem_d  [DEPTH];
    logic [31:0]      data_mem_q [DEPTH];
    logic [31:0]      data_mem_d [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic push;
    logic pop;

    assign in_ready = (count_q != CNT_W'(DEPTH));
    assign pop      = (count_q != '0) && !drain_hold;
    // Writes to r0 are accepted but never stored.
    assign push     = in_valid && in_ready && (in_reg != 5'd0);

    assign count = count_q;
    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_W'(DEPTH));

    assign ctrl_writeEnable = pop;
    assign ctrl_writeReg    = pop ? reg_mem_q[head_q]  : 5'd0;
    assign data_writeReg    = pop ? data_mem_q[head_q] : 32'd0;

    always_comb begin
        reg_mem_d  = reg_mem_q;
        data_mem_d = data_mem_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        if (push) begin
            reg_mem_d[tail_q]  = in_reg;
            data_mem_d[tail_q] = in_data;
            tail_d             = tail_q + PTR_W'(1);
        end
        if (pop) begin
            head_d = head_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Walk oldest to youngest so the last match left standing is the youngest entry.
    always_comb begin
        logic [PTR_W-1:0] idx;
        fwd_hitA  = 1'b0;
        fwd_hitB  = 1'b0;
        fwd_dataA = 32'd0;
        fwd_dataB = 32'd0;
        idx       = head_q;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_q + PTR_W'(i);
            if (CNT_W'(i) < count_q) begin
                if ((lookup_regA != 5'd0) && (reg_mem_q[idx] == lookup_regA)) begin
                    fwd_hitA  = 1'b1;
                    fwd_dataA = data_mem_q[idx];
                end
                if ((lookup_regB != 5'd0) && (reg_mem_q[idx] == lookup_regB)) begin
                    fwd_hitB  = 1'b1;
                    fwd_dataB = data_mem_q[idx];
                end
            end
        end
    end

    always_ff @(posedge clock or negedge ctrl_reset) begin
        if (!ctrl_reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                reg_mem_q[i]  <= 5'd0;
                data_mem_q[i] <= 32'd0;
            end
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            reg_mem_q  <= reg_mem_d;
            data_mem_q <= data_mem_d;
        end
    end

endmodule

// File: doc/writeback_queue.md
WRITEBACK_QUEUE -- requirements
Module: writeback_queue

Interface
REQ-001 Parameter: DEPTH, 4, number of pending write entries; power of two, at least 2.
REQ-002 Port: clock  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: ctrl_reset  input  1  reset, asynchronous, active-low; asserted while 0.
REQ-004 Port: in_valid  input  1  producer offers one result this cycle.
REQ-005 Port: in_ready  output  1  queue accepts the offered result this cycle.
REQ-006 Port: in_reg  input  5  destination register index of the offered result.
REQ-007 Port: in_data  input  32  value of the offered result.
REQ-008 Port: drain_hold  input  1  when 1, no entry is issued to the register file this cycle.
REQ-009 Port: ctrl_writeEnable  output  1  register-file write enable.
REQ-010 Port: ctrl_writeReg  output  5  register-file write index.
REQ-011 Port: data_writeReg  output  32  register-file write data.
REQ-012 Port: lookup_regA, lookup_regB  input  5 each  read indices being fetched this cycle.
REQ-013 Port: fwd_hitA, fwd_hitB  output  1 each  a pending entry targets the lookup index.
REQ-014 Port: fwd_dataA, fwd_dataB  output  32 each  data of the youngest matching pending entry.
REQ-015 Port: count  output  log2(DEPTH)+1  number of pending entries; also empty and full outputs, 1 bit each.

Function
REQ-016 Storage SHALL be a circular FIFO of DEPTH entries {reg[4:0], data[31:0]} with head/tail pointers wrapping modulo DEPTH.
REQ-017 in_ready SHALL be 1 exactly when count < DEPTH, derived from registered state only, with no combinational path from in_valid or drain_hold.
REQ-018 Push: in_valid && in_ready && in_reg != 0 SHALL store the entry at tail on the clock edge; tail and count advance.
REQ-019 in_valid && in_ready && in_reg == 0 SHALL be accepted and discarded: no entry stored, count unchanged.
REQ-020 Issue: when count > 0 && !drain_hold, ctrl_writeEnable SHALL be 1, with ctrl_writeReg/data_writeReg equal to the head entry, combinationally from registered state.
REQ-021 The head SHALL be popped on the same edge on which the register file captures it.
REQ-022 When count == 0 or drain_hold == 1, ctrl_writeEnable SHALL be 0, and ctrl_writeReg/data_writeReg SHALL be 0.
REQ-023 Ordering: entries SHALL be issued strictly in acceptance order; multiple entries for one register are never merged or reordered.
REQ-024 Latency: an entry accepted at edge N SHALL be issued no earlier than the cycle following edge N; with an empty queue and no hold, it is issued exactly that cycle.
REQ-025 Simultaneous push and pop in one cycle SHALL leave count unchanged and advance both pointers.
REQ-026 Push is impossible when count == DEPTH; pop when count == 0 SHALL be a no-op.
REQ-027 Forwarding: fwd_hitX SHALL be 1 iff lookup_regX != 0 and any pending entry, including the head being issued this cycle, has reg == lookup_regX.
REQ-028 fwd_dataX SHALL be the data of the youngest such entry; it SHALL be 0 when fwd_hitX is 0.
REQ-029 The offered-but-not-yet-accepted in_data SHALL NOT be forwarded.
REQ-030 empty SHALL equal (count == 0), and full SHALL equal (count == DEPTH).

Reset
REQ-031 While ctrl_reset == 0: head = tail = 0, count = 0, empty = 1, full = 0, in_ready = 1, ctrl_writeEnable = 0, ctrl_writeReg = 0, data_writeReg = 0, fwd_hitA/B = 0, fwd_dataA/B = 0.
REQ-032 Reset asserted mid-operation SHALL discard all pending entries immediately, without waiting for a clock edge, and issue no further writes from them.
REQ-033 The first push SHALL be honoured on the first rising edge after ctrl_reset returns to 1.

Verification
REQ-034 Single write: empty queue, push r5=0x0000_00AA -> next cycle ctrl_writeEnable=1, ctrl_writeReg=5, data=0xAA; the cycle after that, empty=1 and ctrl_writeEnable=0.
REQ-035 Fill/backpressure: drain_hold=1, push r1..r4 = 0x11..0x44 -> count=4, full=1, in_ready=0; a fifth offer is not taken; release hold -> writes r1..r4 on 4 consecutive cycles in order.
REQ-036 r0 discard: push r0=0xFFFF_FFFF -> count stays 0, no ctrl_writeEnable pulse, fwd_hitA=0 with lookup_regA=0.
REQ-037 Forwarding youngest: with hold=1, push r7=0x1 then r7=0x2, lookup_regA=7, lookup_regB=8 -> fwd_hitA=1, fwd_dataA=0x2, fwd_hitB=0, fwd_dataB=0.
REQ-038 Wrap and simultaneous push/pop: stream 10 pushes r1..r10 at one per cycle with hold=0 -> count never exceeds 1, writes appear in order with data intact across pointer wrap.
REQ-039 Async reset: with 3 entries pending, drop ctrl_reset between edges -> count=0 and ctrl_writeEnable=0 before the next edge; none of the 3 entries is written after release.
